// File: rtl/reset_sequencer_if.sv
// Purpose : bundle of enable/key/power-reset inputs and the sequenced reset outputs.
// Latency : n/a (signal bundle only).
// Backpr. : none; every signal is a plain level sampled on each clk25 edge.
//
// Ports (modport master = the sequencer, slave = the system side):
//   enable, pwr_rst, key_reset, key_clr    -> into the sequencer
//   rst_video, rst_periph, rst_cpu,
//   clr_screen, busy                       <- out of the sequencer
interface reset_sequencer_if;
  logic enable;
  logic pwr_rst;
  logic key_reset;
  logic key_clr;
  logic rst_video;
  logic rst_periph;
  logic rst_cpu;
  logic clr_screen;
  logic busy;

  modport master (
    input  enable,
    input  pwr_rst,
    input  key_reset,
    input  key_clr,
    output rst_video,
    output rst_periph,
    output rst_cpu,
    output clr_screen,
    output busy
  );

  modport slave (
    output enable,
    output pwr_rst,
    output key_reset,
    output key_clr,
    input  rst_video,
    input  rst_periph,
    input  rst_cpu,
    input  clr_screen,
    input  busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// Purpose : orders reset release (video, peripherals, CPU) after power-on; RESET key
//           re-resets only the CPU, CLR SCREEN key issues a one-cycle clear pulse.
// Latency : outputs registered; key action lands 2 sync + DEBOUNCE_TICKS ticks after a stable press.
// Backpr. : none; keys pressed outside the accepting states are dropped, never queued.
//
// Ports:
//   clk25  - system clock
//   rst_n  - synchronous active-low reset (clears everything, including key debouncers)
//   bus    - reset_sequencer_if.master: enable tick, pwr_rst, raw keys in;
//            rst_video/rst_periph/rst_cpu/clr_screen/busy out
module reset_sequencer #(
  parameter int HOLD_TICKS     = 32,
  parameter int STEP_TICKS     = 8,
  parameter int DEBOUNCE_TICKS = 255,
  parameter int CNT_W          = 8
) (
  input  logic               clk25,
  input  logic               rst_n,
  reset_sequencer_if.master  bus
);

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_VID  = 3'd1;
  localparam logic [2:0] S_PER  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_CPU  = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

  // Key index 0 = RESET key, 1 = CLR SCREEN key.
  localparam int KEYS    = 2;
  localparam int KEY_RST = 0;
  localparam int KEY_CLR = 1;

  logic [KEYS-1:0]  key_raw;
  logic [KEYS-1:0]  sync_a;
  logic [KEYS-1:0]  sync_b;
  logic [KEYS-1:0]  deb_lvl;
  logic [KEYS-1:0]  deb_rise;
  logic [CNT_W-1:0] deb_cnt [KEYS];

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  logic rst_video_q;
  logic rst_periph_q;
  logic rst_cpu_q;
  logic clr_screen_q;
  logic busy_q;

  assign key_raw = {bus.key_clr, bus.key_reset};

  // ---------------------------------------------------------------------------
  // Key synchronisers and debouncers. These only see rst_n: a held pwr_rst
  // must not lose key history, so a press spanning the power-up is still
  // debounced correctly (and then discarded by the FSM).
  // ---------------------------------------------------------------------------

  // A rising event fires on the very tick the debounced level flips to 1, so
  // the FSM reacts on the same edge the level updates instead of one later.
  always_comb begin
    deb_rise = '0;
    for (int k = 0; k < KEYS; k++) begin
      deb_rise[k] = bus.enable && sync_b[k] && !deb_lvl[k] && (deb_cnt[k] == DEB_LAST);
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      deb_lvl <= '0;
      for (int k = 0; k < KEYS; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      // Synchronisers run every clock; only the debounce counting is gated.
      sync_a <= key_raw;
      sync_b <= sync_a;
      if (bus.enable) begin
        for (int k = 0; k < KEYS; k++) begin
          if (sync_b[k] != deb_lvl[k]) begin
            if (deb_cnt[k] == DEB_LAST) begin
              deb_lvl[k] <= sync_b[k];
              deb_cnt[k] <= '0;
            end else begin
              deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
          end else begin
            // Any agreeing tick restarts the stability window.
            deb_cnt[k] <= '0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Release sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: if (bus.enable && cnt == HOLD_LAST) state_nxt = S_VID;
      S_VID:  if (bus.enable && cnt == STEP_LAST) state_nxt = S_PER;
      S_PER:  if (bus.enable && cnt == STEP_LAST) state_nxt = S_RUN;
      S_RUN:  if (deb_rise[KEY_RST])              state_nxt = S_CPU;
      S_CPU:  if (bus.enable && cnt == HOLD_LAST) state_nxt = S_RUN;
      default:                                    state_nxt = S_HOLD;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as the state register. S_CPU decodes only rst_cpu, which is what keeps
  // video and peripherals out of reset during a CPU-only reset, and rst_cpu
  // is released only on entry to S_RUN, after both others are already low.
  always_ff @(posedge clk25) begin
    if (!rst_n || bus.pwr_rst) begin
      state        <= S_HOLD;
      cnt          <= '0;
      rst_video_q  <= 1'b1;
      rst_periph_q <= 1'b1;
      rst_cpu_q    <= 1'b1;
      busy_q       <= 1'b1;
      clr_screen_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (bus.enable) begin
        cnt <= cnt + 1'b1;
      end
      rst_video_q  <= (state_nxt == S_HOLD);
      rst_periph_q <= (state_nxt == S_HOLD) || (state_nxt == S_VID);
      rst_cpu_q    <= (state_nxt != S_RUN);
      busy_q       <= (state_nxt != S_RUN);
      // The clear event is already a single enable-qualified cycle, so the
      // registered pulse is exactly one clk25 cycle wide.
      clr_screen_q <= deb_rise[KEY_CLR] && ((state == S_RUN) || (state == S_CPU));
    end
  end

  assign bus.rst_video  = rst_video_q;
  assign bus.rst_periph = rst_periph_q;
  assign bus.rst_cpu    = rst_cpu_q;
  assign bus.clr_screen = clr_screen_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose : directed bench for reset_sequencer (HOLD=4, STEP=2, DEBOUNCE=3).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  reset_sequencer_if bus_if ();

  reset_sequencer #(
    .HOLD_TICKS     (4),
    .STEP_TICKS     (2),
    .DEBOUNCE_TICKS (3),
    .CNT_W          (8)
  ) dut (
    .clk25 (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic p, input logic c,
                         input logic b, input logic cl);
    chk({tag, "_vid"},  bus_if.rst_video,  v);
    chk({tag, "_per"},  bus_if.rst_periph, p);
    chk({tag, "_cpu"},  bus_if.rst_cpu,    c);
    chk({tag, "_busy"}, bus_if.busy,       b);
    chk({tag, "_clr"},  bus_if.clr_screen, cl);
  endtask

  // Power-up timing from a reset edge: video falls at +4, periph at +6, cpu/busy at +8.
  task automatic run_powerup(input string tag);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_all($sformatf("%s_e%0d", tag, k), (k < 4), (k < 6), (k < 8), (k < 8), 1'b0);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.enable    = 1'b1;
    bus_if.pwr_rst   = 1'b0;
    bus_if.key_reset = 1'b0;
    bus_if.key_clr   = 1'b0;

    // Test 1: reset values, then release order.
    step();
    chk_all("t1_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    run_powerup("t1");

    // Test 2: enable on even edges only doubles every interval.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      bus_if.enable = (k % 2 == 0);
      step();
      chk_all($sformatf("t2_e%0d", k), (k < 8), (k < 12), (k < 16), (k < 16), 1'b0);
    end
    bus_if.enable = 1'b1;

    // Test 3: single-cycle pwr_rst while in S_PER restarts the sequence.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    chk("t3_in_per_vid", bus_if.rst_video, 1'b0);
    chk("t3_in_per_per", bus_if.rst_periph, 1'b0);
    bus_if.pwr_rst = 1'b1;
    step();
    chk_all("t3_pwr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    bus_if.pwr_rst = 1'b0;
    run_powerup("t3");

    // Test 4: bouncing RESET key has no effect.
    bus_if.key_reset = 1'b1; step(); step();
    bus_if.key_reset = 1'b0; step();
    bus_if.key_reset = 1'b1; step(); step();
    bus_if.key_reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all($sformatf("t4_bounce_%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Stable press: CPU-only reset for 4 cycles starting 5 cycles in, no retrigger.
    bus_if.key_reset = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk_all($sformatf("t4_hold_%0d", j), 1'b0, 1'b0, (j >= 5 && j <= 8), (j >= 5 && j <= 8), 1'b0);
    end
    bus_if.key_reset = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("t4_release_cpu_%0d", j), bus_if.rst_cpu, 1'b0);
    end

    // Test 5: CLR SCREEN in S_RUN gives one pulse.
    bus_if.key_clr = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk_all($sformatf("t5_run_%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, (j == 5));
    end
    bus_if.key_clr = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("t5_run_idle_clr_%0d", j), bus_if.clr_screen, 1'b0);
    end
    // Same stimulus held in S_HOLD (pwr_rst high): pulse discarded.
    bus_if.pwr_rst = 1'b1;
    bus_if.key_clr = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk_all($sformatf("t5_hold_%0d", j), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    bus_if.pwr_rst = 1'b0;
    bus_if.key_clr = 1'b0;
    run_powerup("t5_after");

    // Test 6: rst_n pulse in mid-S_CPU.
    bus_if.key_reset = 1'b1;
    for (int j = 1; j <= 6; j++) step();
    chk("t6_in_cpu_cpu", bus_if.rst_cpu, 1'b1);
    chk("t6_in_cpu_vid", bus_if.rst_video, 1'b0);
    bus_if.key_reset = 1'b0;
    rst_n = 1'b0;
    step();
    chk_all("t6_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    run_powerup("t6");

    // Simultaneous RESET and CLR SCREEN presses in S_RUN act on the same edge.
    bus_if.key_reset = 1'b1;
    bus_if.key_clr   = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk_all($sformatf("t7_both_%0d", j), 1'b0, 1'b0, (j >= 5 && j <= 8), (j >= 5 && j <= 8), (j == 5));
    end
    bus_if.key_reset = 1'b0;
    bus_if.key_clr   = 1'b0;
    for (int j = 1; j <= 4; j++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
